// File: rtl/sub_pipe_param.sv
// sub_pipe_param
// Pipelined WIDTH-bit subtractor (result = A - B) that resolves CHUNK bits per
// stage, so no borrow chain is wider than one chunk. The borrow from chunk k is
// registered and consumed by stage k+2. The operands and mode ride along with
// each beat. The whole pipe advances together under one global stall.
//
// Parameters
//   WIDTH : operand/result width (8..64, multiple of CHUNK)
//   CHUNK : bits resolved per stage; NSTAGE = WIDTH/CHUNK = latency in cycles
//
// Ports
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   in_valid     : operand beat present on A/B/signed_mode
//   in_ready     : beat is accepted this cycle (equals the global advance)
//   A, B         : minuend, subtrahend
//   signed_mode  : 1 = two's-complement operands, 0 = unsigned
//   out_valid    : result beat present
//   out_ready    : downstream accepts the result
//   result       : A - B mod 2^WIDTH, or the clamped value when saturating
//   borrow       : unsigned A < B (reported in both modes)
//   overflow     : signed overflow, only when signed_mode = 1
//   sat          : result was clamped
//
// Build option
//   SUB_SAT_EN : when defined, an unsigned borrow clamps the result to 0. A
//                signed overflow clamps it to the most positive or most
//                negative value, depending on the sign of A. When the macro is
//                undefined, sat is tied low and no clamp logic exists.

module sub_pipe_param #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             borrow,
  output logic             overflow,
  output logic             sat
);

  localparam int NSTAGE = WIDTH / CHUNK;

  // Stage registers; index k holds the state after stage k+1.
  // Element NSTAGE-1 is the output register.
  logic             v_q  [NSTAGE];
  logic [WIDTH-1:0] a_q  [NSTAGE];
  logic [WIDTH-1:0] b_q  [NSTAGE];
  logic [WIDTH-1:0] r_q  [NSTAGE];
  logic             bw_q [NSTAGE];
  logic             md_q [NSTAGE];
  logic             ovf_q;

  // Inputs seen by each stage: primary inputs for stage 1, else the
  // previous stage register.
  logic             src_v  [NSTAGE];
  logic [WIDTH-1:0] src_a  [NSTAGE];
  logic [WIDTH-1:0] src_b  [NSTAGE];
  logic [WIDTH-1:0] src_r  [NSTAGE];
  logic             src_bw [NSTAGE];
  logic             src_md [NSTAGE];

  logic [WIDTH-1:0] nxt_r  [NSTAGE];
  logic             nxt_bw [NSTAGE];
  logic [CHUNK:0]   diff;

  logic [WIDTH-1:0] raw;
  logic             a_msb;
  logic             b_msb;
  logic             fin_md;
  logic             raw_ovf;
  logic [WIDTH-1:0] fin_res;

  logic advance;

  // A full output register that is not being drained freezes every stage.
  assign advance  = !v_q[NSTAGE-1] || out_ready;
  assign in_ready = advance;

  // Each stage subtracts its own chunk with a CHUNK+1 bit subtract.
  // Bit CHUNK of that subtract is the borrow handed to the next stage.
  always_comb begin
    src_v[0]  = in_valid;
    src_a[0]  = A;
    src_b[0]  = B;
    src_r[0]  = '0;
    src_bw[0] = 1'b0;
    src_md[0] = signed_mode;
    for (int k = 1; k < NSTAGE; k++) begin
      src_v[k]  = v_q[k-1];
      src_a[k]  = a_q[k-1];
      src_b[k]  = b_q[k-1];
      src_r[k]  = r_q[k-1];
      src_bw[k] = bw_q[k-1];
      src_md[k] = md_q[k-1];
    end
    diff = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      diff = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
           - {1'b0, src_b[k][k*CHUNK +: CHUNK]}
           - {{CHUNK{1'b0}}, src_bw[k]};
      nxt_r[k]                   = src_r[k];
      nxt_r[k][k*CHUNK +: CHUNK] = diff[CHUNK-1:0];
      nxt_bw[k]                  = diff[CHUNK];
    end
  end

  // The last stage sees the full raw difference and the operand sign bits.
  // Overflow is derived from them before the output register.
  assign raw     = nxt_r[NSTAGE-1];
  assign a_msb   = src_a[NSTAGE-1][WIDTH-1];
  assign b_msb   = src_b[NSTAGE-1][WIDTH-1];
  assign fin_md  = src_md[NSTAGE-1];
  assign raw_ovf = fin_md && (a_msb != b_msb) && (raw[WIDTH-1] != a_msb);

`ifdef SUB_SAT_EN
  logic clamp;
  logic sat_q;

  // Signed mode clamps only on overflow. Unsigned mode clamps on borrow.
  // A signed borrow without overflow is an ordinary negative result.
  always_comb begin
    clamp   = fin_md ? raw_ovf : nxt_bw[NSTAGE-1];
    fin_res = raw;
    if (clamp) begin
      if (!fin_md)
        fin_res = '0;
      else if (a_msb)
        fin_res = {1'b1, {(WIDTH-1){1'b0}}};
      else
        fin_res = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sat_q <= 1'b0;
    else if (advance)
      sat_q <= clamp;
  end

  assign sat = sat_q;
`else
  assign fin_res = raw;
  assign sat     = 1'b0;
`endif

  // All stage registers load together on advance.
  // The output stage takes the finished (possibly clamped) result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSTAGE; k++) begin
        v_q[k]  <= 1'b0;
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        r_q[k]  <= '0;
        bw_q[k] <= 1'b0;
        md_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < NSTAGE; k++) begin
        v_q[k]  <= src_v[k];
        a_q[k]  <= src_a[k];
        b_q[k]  <= src_b[k];
        r_q[k]  <= nxt_r[k];
        bw_q[k] <= nxt_bw[k];
        md_q[k] <= src_md[k];
      end
      r_q[NSTAGE-1] <= fin_res;
      ovf_q         <= raw_ovf;
    end
  end

  assign out_valid = v_q[NSTAGE-1];
  assign result    = r_q[NSTAGE-1];
  assign borrow    = bw_q[NSTAGE-1];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_sub_pipe_param.sv
// tb_sub_pipe_param
// Bench for sub_pipe_param at WIDTH=16, CHUNK=8 (latency 2).
// The expected results come from integer arithmetic on the operands. The
// clamp rules follow SUB_SAT_EN when that macro is defined for the build.

module tb_sub_pipe_param;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        signed_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        borrow;
  logic        overflow;
  logic        sat;

  typedef struct {
    logic [15:0] res;
    logic        borrow;
    logic        ovf;
    logic        sat;
  } exp_t;

  exp_t model_q[$];
  int   errors    = 0;
  int   checks    = 0;
  int   out_count = 0;
  int   acc_count = 0;
  bit   rnd_done  = 0;

  sub_pipe_param #(.WIDTH(16), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .signed_mode(signed_mode), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .borrow(borrow),
    .overflow(overflow), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer subtraction on the operand values.
  function automatic exp_t modelSub(input logic [15:0] a, input logic [15:0] b, input logic m);
    exp_t e;
    int ua, ub, sa, sb, sd;
    ua = int'(a);
    ub = int'(b);
    sa = ua >= 32768 ? ua - 65536 : ua;
    sb = ub >= 32768 ? ub - 65536 : ub;
    sd = sa - sb;
    e.res    = 16'((ua - ub) & 32'hFFFF);
    e.borrow = ua < ub;
    e.ovf    = m && (sd > 32767 || sd < -32768);
    e.sat    = 1'b0;
`ifdef SUB_SAT_EN
    if (m ? e.ovf : e.borrow) begin
      e.sat = 1'b1;
      if (!m)         e.res = 16'h0000;
      else if (sa >= 0) e.res = 16'h7FFF;
      else            e.res = 16'h8000;
    end
`endif
    return e;
  endfunction

  // Scoreboard. It runs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_in_ready", in_ready, 1);
      model_q.delete();
    end else begin
      checkOutput("in_ready_rule", in_ready, !out_valid || out_ready);
      if (out_valid) begin
        checkOutput("out_has_expected", model_q.size() != 0, 1);
        if (model_q.size() != 0) begin
          checkOutput("result", result, model_q[0].res);
          checkOutput("borrow", borrow, model_q[0].borrow);
          checkOutput("overflow", overflow, model_q[0].ovf);
          checkOutput("sat", sat, model_q[0].sat);
          if (out_ready) begin
            void'(model_q.pop_front());
            out_count++;
          end
        end
      end
      if (in_valid && in_ready) begin
        model_q.push_back(modelSub(A, B, signed_mode));
        acc_count++;
      end
    end
  end

  // Present a beat and hold it until it is accepted (bounded).
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic m);
    int w = 0;
    A = a; B = b; signed_mode = m; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 200) begin
        checkOutput("accept_timeout", w, 0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((model_q.size() != 0 || out_valid) && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    checkOutput("drain_empty", model_q.size(), 0);
  endtask

  // One beat into an empty pipe with out_ready=1.
  // The result must appear exactly two cycles after the beat is presented.
  task automatic sendDirected(input string tag, input logic [15:0] a, input logic [15:0] b,
                              input logic m, input logic [15:0] er, input logic eb,
                              input logic eo, input logic es);
    A = a; B = b; signed_mode = m; in_valid = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput({tag, "_not_early"}, out_valid, 0);
    @(posedge clk); #1;
    checkOutput({tag, "_out_valid"}, out_valid, 1);
    checkOutput({tag, "_result"}, result, er);
    checkOutput({tag, "_borrow"}, borrow, eb);
    checkOutput({tag, "_overflow"}, overflow, eo);
    checkOutput({tag, "_sat"}, sat, es);
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] randVal();
    logic [15:0] corners [5];
    corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  initial begin
    exp_t pin;
    int   base;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; signed_mode = 1'b0;

    // Hand-computed values that pin the reference model.
    pin = modelSub(16'h0100, 16'h0001, 1'b0);
    checkOutput("model_cross_chunk", pin.res, 16'h00FF);
    pin = modelSub(16'h0000, 16'h0001, 1'b0);
    checkOutput("model_borrow", pin.borrow, 1);
    pin = modelSub(16'h8000, 16'h0001, 1'b1);
    checkOutput("model_ovf", pin.ovf, 1);

    // Asynchronous reset must clear the outputs before any clock edge.
    #1;
    checkOutput("por_out_valid", out_valid, 0);
    checkOutput("por_result", result, 0);
    checkOutput("por_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // The beat goes in on the first edge after reset release.
    sendDirected("cross_chunk", 16'h0100, 16'h0001, 1'b0, 16'h00FF, 0, 0, 0);
    drain();
`ifdef SUB_SAT_EN
    sendDirected("uns_under", 16'h0000, 16'h0001, 1'b0, 16'h0000, 1, 0, 1);
    drain();
    sendDirected("sgn_neg_ovf", 16'h8000, 16'h0001, 1'b1, 16'h8000, 0, 1, 1);
    drain();
    sendDirected("sgn_pos_ovf", 16'h7FFF, 16'hFFFF, 1'b1, 16'h7FFF, 1, 1, 1);
    drain();
`else
    sendDirected("uns_under", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1, 0, 0);
    drain();
    sendDirected("sgn_neg_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 0, 1, 0);
    drain();
    sendDirected("sgn_pos_ovf", 16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1, 1, 0);
    drain();
`endif
    sendDirected("sgn_no_ovf", 16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1, 0, 0);
    drain();

    // Four back-to-back beats, with the output stalled in cycles 3-5.
    base = out_count;
    fork
      begin
        applyStimulus(16'h1000, 16'h0001, 1'b0);
        applyStimulus(16'h0000, 16'h0100, 1'b0);
        applyStimulus(16'h8000, 16'h7FFF, 1'b1);
        applyStimulus(16'h00FF, 16'h00FF, 1'b1);
      end
      begin
        repeat (2) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checkOutput("b2b_in_ready_low", in_ready, 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    checkOutput("b2b_count", out_count - base, 4);

    // Reset with two beats in flight; neither beat may ever emerge.
    applyStimulus(16'h5555, 16'h1111, 1'b0);
    applyStimulus(16'h6666, 16'h1111, 1'b0);
    checkOutput("inflight_pre_rst", out_valid, 1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_result", result, 0);
    checkOutput("midrst_borrow", borrow, 0);
    checkOutput("midrst_overflow", overflow, 0);
    checkOutput("midrst_sat", sat, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    sendDirected("post_rst", 16'h1234, 16'h0034, 1'b0, 16'h1200, 0, 0, 0);
    drain();

    // Random traffic with random backpressure and bubbles.
    base = out_count;
    acc_count = 0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
          applyStimulus(randVal(), randVal(), 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    checkOutput("rand_accepted", acc_count, 10000);
    checkOutput("rand_delivered", out_count - base, acc_count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sub_pipe_param.md
SUB_PIPE_PARAM -- requirements
Module: sub_pipe_param

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits; legal values 8..64, multiple of CHUNK.
REQ-002 SHALL have parameter CHUNK, default 8: bits resolved per pipeline stage; NSTAGE = WIDTH/CHUNK.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port in_valid  input  1  operand beat present.
REQ-007 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-008 SHALL have port A  input  WIDTH  minuend.
REQ-009 SHALL have port B  input  WIDTH  subtrahend.
REQ-010 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-011 SHALL have port out_valid  output  1  result beat present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port result  output  WIDTH  A-B, mod 2^WIDTH or saturated.
REQ-014 SHALL have port borrow  output  1  unsigned A<B, independent of mode.
REQ-015 SHALL have port overflow  output  1  signed overflow; 0 when signed_mode=0.
REQ-016 SHALL have port sat  output  1  result was clamped.

Function
REQ-017 SHALL resolve chunk k (bits k*CHUNK+CHUNK-1..k*CHUNK) in stage k+1, propagating borrow forward through pipeline registers; no WIDTH-bit combinational borrow chain.
REQ-018 SHALL carry A, B upper chunks and signed_mode alongside each beat until consumed.
REQ-019 SHALL have latency exactly NSTAGE cycles from accepted beat (in_valid&in_ready) to out_valid with no stall.
REQ-020 SHALL use global stall: advance = !out_valid | out_ready; in_ready = advance; every stage register loads only when advance=1.
REQ-021 SHALL sustain one beat per cycle while out_ready=1; beats never dropped, duplicated or reordered.
REQ-022 SHALL hold result, borrow, overflow, sat, out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL propagate bubbles: stage valid bit loads in_valid (stage 1) or previous stage valid when advancing.
REQ-024 SHALL set borrow = final chunk borrow-out; overflow = signed_mode & (A[MSB]!=B[MSB]) & (raw[MSB]!=A[MSB]).
REQ-025 SHALL, when in_valid=1 and in_ready=0, ignore A/B; upstream holds them.

Reset
REQ-026 SHALL, on rst=1, immediately clear all stage valid bits, out_valid=0, result=0, borrow=0, overflow=0, sat=0, independent of clk.
REQ-027 SHALL drive in_ready=1 during and after reset; beats in flight at reset are discarded.
REQ-028 SHALL accept a beat on the first rising clk edge after rst deasserts.

Configuration
REQ-029 SHALL recognise macro SUB_SAT_EN.
REQ-030 SHALL, with SUB_SAT_EN defined: unsigned borrow -> result 0; signed overflow -> result 2^(WIDTH-1)-1 if A non-negative else -2^(WIDTH-1); sat=1 on clamp; borrow/overflow still report raw condition.
REQ-031 SHALL, without SUB_SAT_EN: result = raw A-B mod 2^WIDTH, sat tied 0, no saturation logic synthesised.

Verification (WIDTH=16, CHUNK=8, latency 2)
REQ-032 Unsigned, A=0x0100, B=0x0001, out_ready=1 -> 2 cycles later result=0x00FF, borrow=0, overflow=0 (cross-chunk borrow).
REQ-033 Unsigned, A=0x0000, B=0x0001 -> result=0xFFFF, borrow=1, sat=0; with SUB_SAT_EN result=0x0000, sat=1.
REQ-034 Signed, A=0x8000, B=0x0001 -> result=0x7FFF, overflow=1, borrow=0; with SUB_SAT_EN result=0x8000, sat=1.
REQ-035 Back-to-back 4 beats, out_ready low cycles 3-5 -> in_ready low those cycles, outputs held, all 4 results in order, none lost.
REQ-036 Assert rst mid-stream with 2 beats in flight -> out_valid=0 and outputs 0 immediately; next accepted beat after release emerges 2 cycles later, old beats never appear.
REQ-037 10000 random A, B, signed_mode with random out_ready/in_valid -> every result/borrow/overflow/sat matches reference model per REQ-024/030/031.
